// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection bits and
// the BRAM-port grant encoding used by the subordinate's arbiter.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        e_okay   = 2'b00,
        e_exokay = 2'b01,
        e_slverr = 2'b10,
        e_decerr = 2'b11
    } axi4_lite_resp_e;

    localparam logic [2:0] axi4_lite_default_prot_gp = 3'b011;

    typedef enum logic {
        e_grant_wr = 1'b0,
        e_grant_rd = 1'b1
    } axi4_lite_grant_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; read data appears
// the cycle after a read access and holds until the next one.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int unsigned els_p         = 4096,
    parameter int unsigned data_width_p  = 64,
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned mask_width_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]  data_o
);

    logic [data_width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                for (int unsigned i = 0; i < mask_width_lp; i++) begin
                    if (write_mask_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= data_i[8*i +: 8];
                    end
                end
            end else begin
                data_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_bram_subordinate.sv
// AXI4-Lite subordinate over a single-port byte-masked BRAM: one holding
// register per AR/AW/W channel, alternating arbitration for the BRAM port.
module axi4_lite_bram_subordinate
    import axi4_lite_pkg::*;
#(
    parameter int unsigned                   axi_addr_width_p  = 28,
    parameter int unsigned                   axi_data_width_p  = 64,
    parameter int unsigned                   axi_wstrb_width_p = axi_data_width_p / 8,
    parameter int unsigned                   mem_els_p         = 4096,
    parameter logic [axi_addr_width_p-1:0]   base_addr_p       = '0
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [axi_addr_width_p-1:0]  araddr_i,
    input  logic [2:0]                   arprot_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [axi_data_width_p-1:0]  rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    input  logic [axi_addr_width_p-1:0]  awaddr_i,
    input  logic [2:0]                   awprot_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    input  logic [axi_data_width_p-1:0]  wdata_i,
    input  logic [axi_wstrb_width_p-1:0] wstrb_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    output logic [1:0]                   bresp_o,
    output logic                         bvalid_o,
    input  logic                         bready_i
);

    localparam int unsigned off_lp   = $clog2(axi_wstrb_width_p);
    localparam int unsigned idx_w_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam logic [axi_addr_width_p:0] els_lp  = (axi_addr_width_p + 1)'(mem_els_p);
    localparam logic [axi_addr_width_p:0] base_lp = {1'b0, base_addr_p};

    typedef struct packed {
        logic                in_range;
        logic [idx_w_lp-1:0] idx;
    } decode_s;

    // One extra bit on the subtraction exposes addresses below the base.
    function automatic decode_s decode(input logic [axi_addr_width_p-1:0] addr);
        logic [axi_addr_width_p:0] diff;
        logic [axi_addr_width_p:0] word;
        decode_s                   d;
        diff       = {1'b0, addr} - base_lp;
        word       = {1'b0, diff[axi_addr_width_p-1:0]} >> off_lp;
        d.in_range = ~diff[axi_addr_width_p] && (word < els_lp);
        d.idx      = word[idx_w_lp-1:0];
        return d;
    endfunction

    logic                          ar_full_q, ar_full_d;
    logic [axi_addr_width_p-1:0]   ar_addr_q, ar_addr_d;
    logic                          aw_full_q, aw_full_d;
    logic [axi_addr_width_p-1:0]   aw_addr_q, aw_addr_d;
    logic                          w_full_q, w_full_d;
    logic [axi_data_width_p-1:0]   w_data_q, w_data_d;
    logic [axi_wstrb_width_p-1:0]  w_strb_q, w_strb_d;
    logic                          rd_inflight_q, rd_inflight_d;
    logic                          rd_oor_q, rd_oor_d;
    logic                          rvalid_q, rvalid_d;
    logic [axi_data_width_p-1:0]   rdata_q, rdata_d;
    axi4_lite_resp_e               rresp_q, rresp_d;
    logic                          bvalid_q, bvalid_d;
    axi4_lite_resp_e               bresp_q, bresp_d;
    axi4_lite_grant_e              last_grant_q, last_grant_d;

    decode_s                       ar_dec, aw_dec;
    logic                          rd_elig, wr_elig, rd_issue, wr_issue;
    logic                          mem_v;
    logic [idx_w_lp-1:0]           mem_addr;
    logic [axi_data_width_p-1:0]   mem_rdata;
    logic [axi_data_width_p-1:0]   rdata_cur;
    axi4_lite_resp_e               rresp_cur;
    logic                          unused_prot;

    assign unused_prot = ^{arprot_i, awprot_i};

    assign arready_o = ~ar_full_q;
    assign awready_o = ~aw_full_q;
    assign wready_o  = ~w_full_q;

    assign ar_dec = decode(ar_addr_q);
    assign aw_dec = decode(aw_addr_q);

    // The read response is visible straight from the BRAM output in the cycle
    // after issue, then parked in rdata_q if the manager is not ready.
    assign rdata_cur = rd_inflight_q ? (rd_oor_q ? '0 : mem_rdata) : rdata_q;
    assign rresp_cur = rd_inflight_q ? (rd_oor_q ? e_decerr : e_okay) : rresp_q;
    assign rdata_o   = rdata_cur;
    assign rresp_o   = rresp_cur;
    assign rvalid_o  = rvalid_q | rd_inflight_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

    assign rd_elig  = ar_full_q & ~rd_inflight_q & (~rvalid_o | rready_i);
    assign wr_elig  = aw_full_q & w_full_q & ~bvalid_q;
    assign rd_issue = rd_elig & (~wr_elig | (last_grant_q == e_grant_wr));
    assign wr_issue = wr_elig & ~rd_issue;

    assign mem_v    = (rd_issue & ar_dec.in_range) | (wr_issue & aw_dec.in_range);
    assign mem_addr = wr_issue ? aw_dec.idx : ar_dec.idx;

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (axi_data_width_p)
    ) mem (
        .clk_i        (clk_i),
        .v_i          (mem_v),
        .w_i          (wr_issue),
        .addr_i       (mem_addr),
        .data_i       (w_data_q),
        .write_mask_i (w_strb_q),
        .data_o       (mem_rdata)
    );

    always_comb begin
        ar_full_d     = ar_full_q;
        ar_addr_d     = ar_addr_q;
        aw_full_d     = aw_full_q;
        aw_addr_d     = aw_addr_q;
        w_full_d      = w_full_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        rd_inflight_d = rd_issue;
        rd_oor_d      = rd_issue ? ~ar_dec.in_range : rd_oor_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        last_grant_d  = last_grant_q;

        if (rd_issue) begin
            ar_full_d = 1'b0;
        end else if (arvalid_i & arready_o) begin
            ar_full_d = 1'b1;
            ar_addr_d = araddr_i;
        end

        if (wr_issue) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (awvalid_i & awready_o) begin
                aw_full_d = 1'b1;
                aw_addr_d = awaddr_i;
            end
            if (wvalid_i & wready_o) begin
                w_full_d = 1'b1;
                w_data_d = wdata_i;
                w_strb_d = wstrb_i;
            end
        end

        if (rd_inflight_q) begin
            rvalid_d = ~rready_i;
            rdata_d  = rdata_cur;
            rresp_d  = rresp_cur;
        end else if (rready_i) begin
            rvalid_d = 1'b0;
        end

        if (wr_issue) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_dec.in_range ? e_okay : e_decerr;
        end else if (bready_i) begin
            bvalid_d = 1'b0;
        end

        if (rd_issue) begin
            last_grant_d = e_grant_rd;
        end else if (wr_issue) begin
            last_grant_d = e_grant_wr;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ar_full_q     <= 1'b0;
            ar_addr_q     <= '0;
            aw_full_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_full_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            rd_inflight_q <= 1'b0;
            rd_oor_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= e_okay;
            bvalid_q      <= 1'b0;
            bresp_q       <= e_okay;
            last_grant_q  <= e_grant_wr;
        end else begin
            ar_full_q     <= ar_full_d;
            ar_addr_q     <= ar_addr_d;
            aw_full_q     <= aw_full_d;
            aw_addr_q     <= aw_addr_d;
            w_full_q      <= w_full_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            rd_inflight_q <= rd_inflight_d;
            rd_oor_q      <= rd_oor_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            last_grant_q  <= last_grant_d;
        end
    end

endmodule
